// File: rtl/seq_scan_arbiter.sv
// Round-robin shared bit-serial pattern scanner: grants one byte per handshake to one of two
// requesters, shifts it MSB-first through a PAT_W-bit window and counts matches per requester.
module seq_scan_arbiter #(
    parameter int unsigned       PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PAT_RST = 4'b1101,
    parameter int unsigned       CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    output logic             req0_ready,
    output logic             req1_ready,
    output logic             busy,
    output logic             grant_id,
    output logic             match_pulse,
    output logic             match_id,
    output logic [CNT_W-1:0] match_cnt0,
    output logic [CNT_W-1:0] match_cnt1
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q;
    logic [7:0]       byte_q;
    logic [PAT_W-1:0] window_q;
    logic [PAT_W-1:0] pattern_q;
    logic [3:0]       bit_cnt_q;
    logic             last_grant_q;

    logic             winner;
    logic             grant_ok;
    logic [PAT_W-1:0] window_next;
    logic [3:0]       bits_next;
    logic             hit;

    always_comb begin
        winner   = 1'b0;
        grant_ok = 1'b0;
        // With both requesting, the one not served last time wins.
        if (req0_valid && req1_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = ~req0_valid;
        end
        grant_ok   = (state_q == StIdle) && !cfg_we && (req0_valid || req1_valid);
        req0_ready = grant_ok && !winner;
        req1_ready = grant_ok && winner;
    end

    always_comb begin
        window_next = {window_q[PAT_W-2:0], byte_q[7]};
        bits_next   = bit_cnt_q + 4'd1;
        // Only windows filled entirely from the current byte may match.
        hit         = (bits_next >= 4'(PAT_W)) && (window_next == pattern_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            byte_q       <= '0;
            window_q     <= '0;
            pattern_q    <= PAT_RST;
            bit_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            busy         <= 1'b0;
            grant_id     <= 1'b0;
            match_pulse  <= 1'b0;
            match_id     <= 1'b0;
            match_cnt0   <= '0;
            match_cnt1   <= '0;
        end else begin
            match_pulse <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cfg_we) begin
                        pattern_q <= cfg_pattern;
                    end else if (grant_ok) begin
                        byte_q       <= winner ? req1_data : req0_data;
                        grant_id     <= winner;
                        last_grant_q <= winner;
                        window_q     <= '0;
                        bit_cnt_q    <= '0;
                        busy         <= 1'b1;
                        state_q      <= StShift;
                    end
                end
                StShift: begin
                    byte_q    <= {byte_q[6:0], 1'b0};
                    window_q  <= window_next;
                    bit_cnt_q <= bits_next;
                    if (hit) begin
                        match_pulse <= 1'b1;
                        match_id    <= grant_id;
                        if (grant_id) begin
                            if (match_cnt1 != {CNT_W{1'b1}}) match_cnt1 <= match_cnt1 + CNT_W'(1);
                        end else begin
                            if (match_cnt0 != {CNT_W{1'b1}}) match_cnt0 <= match_cnt0 + CNT_W'(1);
                        end
                    end
                    if (bits_next == 4'd8) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
